vliw_banked_memory: RTL
=======================

Name: vliw_banked_memory

Overview:
- Next-generation unified instruction/data memory for the VLIW core.
- Generalises the single-word store into LANES word-interleaved banks, so one fetch returns a full LANES-wide instruction bundle.
- Adds valid/ready request handshakes, a fixed parametrised read latency, byte-enabled LSU writes, and a program-loader write port.
- Adds a hardware clear sequencer that zeroes the array after reset. Sits between fetch/LSU and the backing array.

Parameters:
- DATA_W, 32, bits per word.
- LANES, 4, words per instruction bundle; also the number of banks. Power of two.
- DEPTH, 1024, total words. Must be a multiple of LANES.
- ADDR_W, 32, width of all word addresses.
- READ_LAT, 1, request-to-response cycles. Legal values are 1 and 2; 2 adds an output register stage.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- init_done  out  1  high once the clear sweep completes.
- ld_valid  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader write data.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  LSU word address.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_be  in  DATA_W/8  LSU byte enables.
- lsu_rsp_valid  out  1  LSU read data valid.
- lsu_rdata  out  DATA_W  LSU read data.
- lsu_err  out  1  one-cycle pulse on an out-of-range LSU access.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted.
- if_pc  in  ADDR_W  fetch word address.
- if_rsp_valid  out  1  bundle valid.
- if_bundle  out  LANES*DATA_W  bundle; word 0 in the LSBs.
- if_err  out  1  one-cycle pulse on a misaligned or out-of-range fetch.

Behaviour:
- Reset (rst low, asynchronous): all outputs go to 0 immediately; in-flight responses are discarded; FSM enters CLEAR with row counter 0. Array contents are not reset directly; the sweep zeroes them.
- Organisation: bank = addr mod LANES; row = addr / LANES; DEPTH/LANES rows.
- FSM state CLEAR:
  - Zeroes one full row per cycle across all banks; counter runs 0..DEPTH/LANES-1.
  - lsu_req_ready = if_req_ready = 0; ld_valid is ignored.
  - After the last row: go to RUN and set init_done = 1 on the next edge.
  - CLEAR lasts exactly DEPTH/LANES cycles after rst deasserts.
- FSM state RUN:
  - Remains in RUN until reset.
  - if_req_ready = 1.
  - lsu_req_ready = !ld_valid. The loader has priority; an LSU request is held until accepted.
- Loader writes: when ld_valid in RUN, writes ld_data to the full word at ld_addr in one cycle. An out-of-range address is dropped silently.
- LSU write (accepted with lsu_we = 1): bytes with lsu_be[i] = 1 are updated at the clock edge. No response is generated.
- LSU read (accepted with lsu_we = 0): lsu_rsp_valid = 1 with lsu_rdata exactly READ_LAT cycles later. Responses have no backpressure; back-to-back accepted reads produce back-to-back responses.
- Fetch (accepted request):
  - if_bundle holds words pc..pc+LANES-1, with if_rsp_valid exactly READ_LAT cycles later.
  - The low log2(LANES) bits of pc are ignored (bundle is aligned down). If they are nonzero, if_err pulses alongside if_rsp_valid.
- Out-of-range (addr >= DEPTH):
  - Reads return all-zero data with a normal valid.
  - Writes are dropped.
  - The matching err signal pulses in the response cycle. For LSU writes, lsu_err pulses 1 cycle after acceptance.
- Collisions: a fetch or LSU read of a word written in the same cycle returns the old data (read-before-write). Loader and LSU never write in the same cycle.
- Outputs between responses: lsu_rdata and if_bundle hold their last value while the corresponding valid is low.
- Reset mid-RUN: pending responses never appear; the array is re-cleared.

Decomposition:
- Shared package vliw_mem_pkg holds:
  - constants: default DATA_W, LANES, DEPTH;
  - typedef mem_word_t;
  - typedef bundle_t (LANES x mem_word_t);
  - enum mem_state_e {CLEAR, RUN};
  - addr→bank/row split function.
- One sub-module, vliw_mem_bank: a single-bank synchronous RAM with byte-enable write, read-before-write, and DEPTH/LANES rows. Instantiated LANES times.
- The top level holds the FSM, clear counter, arbitration, latency pipeline and error logic.

Test Plan:
- Release rst with defaults → init_done rises exactly 256 cycles later; both readys stay 0 until then; a fetch at pc 0 returns bundle 0.
- Loader writes addrs 8..11 = 0xA0..0xA3, then fetch pc 8 (READ_LAT 1) → one cycle later if_rsp_valid = 1, if_bundle = {0xA3,0xA2,0xA1,0xA0}, if_err = 0.
- LSU writes 0xDEADBEEF with be 0xF to addr 5, then writes 0x11223344 with be 0x3, then reads addr 5 → lsu_rdata = 0xDEAD3344 one cycle later (two cycles with READ_LAT 2).
- Same-cycle LSU write 0x55 to addr 12 and fetch pc 12 → bundle word 0 = old value; a fetch of pc 12 on the next cycle returns 0x55.
- LSU read addr 2000 and fetch pc 6 → lsu_rdata = 0 with lsu_err pulse; bundle from 4..7 with if_err pulse; ld_valid held high → lsu_req_ready = 0 for those cycles.
- Assert rst during CLEAR at row 100, and again during RUN with a read in flight → outputs zero at once, no stale response appears, clear restarts from row 0 and takes a full 256 cycles.

Source files
------------

// File: rtl/vliw_mem_pkg.sv
// vliw_mem_pkg: shared constants, types and address helpers for the banked VLIW memory.
package vliw_mem_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 4;
    localparam int DEF_DEPTH  = 1024;

    typedef logic [DEF_DATA_W-1:0] mem_word_t;
    typedef mem_word_t [DEF_LANES-1:0] bundle_t;
    typedef enum logic {CLEAR, RUN} mem_state_e;
    typedef struct packed {
        logic [31:0] row;
        logic [31:0] bank;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [31:0] addr, input int lb);
        addr_split_t s;
        s.row  = addr >> lb;
        s.bank = addr & ((32'd1 << lb) - 32'd1);
        return s;
    endfunction
endpackage

// File: rtl/vliw_mem_bank.sv
// vliw_mem_bank: one word-interleaved bank with a byte-enabled write port and
// independent fetch/LSU read ports; reads return pre-write data on a same-row write.
module vliw_mem_bank
    import vliw_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_DEPTH / DEF_LANES,
    parameter int ROW_W  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ROW_W-1:0]  wrow,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic              if_re,
    input  logic [ROW_W-1:0]  if_row,
    input  logic              if_zero,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              lsu_re,
    input  logic [ROW_W-1:0]  lsu_row,
    input  logic              lsu_zero,
    output logic [DATA_W-1:0] lsu_rdata
);
    logic [DATA_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++)
            if (we && be[i]) mem[wrow][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    // Read registers only move on an accepted read so responses hold between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata  <= '0;
            lsu_rdata <= '0;
        end else begin
            if (if_re)  if_rdata  <= if_zero  ? '0 : mem[if_row];
            if (lsu_re) lsu_rdata <= lsu_zero ? '0 : mem[lsu_row];
        end
    end
endmodule

// File: rtl/vliw_banked_memory.sv
// vliw_banked_memory: LANES-bank unified I/D memory with post-reset clear sweep,
// loader-priority write arbitration, fixed-latency LSU/fetch responses and error pulses.
module vliw_banked_memory
    import vliw_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LANES    = DEF_LANES,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_done,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic                    lsu_we,
    input  logic [ADDR_W-1:0]       lsu_addr,
    input  logic [DATA_W-1:0]       lsu_wdata,
    input  logic [DATA_W/8-1:0]     lsu_be,
    output logic                    lsu_rsp_valid,
    output logic [DATA_W-1:0]       lsu_rdata,
    output logic                    lsu_err,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_W-1:0]       if_pc,
    output logic                    if_rsp_valid,
    output logic [LANES*DATA_W-1:0] if_bundle,
    output logic                    if_err
);
    localparam int ROWS  = DEPTH / LANES;
    localparam int ROW_W = $clog2(ROWS);
    localparam int LB    = $clog2(LANES);

    mem_state_e state, state_nx;
    logic [ROW_W-1:0] cnt;
    logic clearing;
    addr_split_t ld_s, lsu_s, if_s;
    logic ld_oor, lsu_oor, if_oor, ld_wr, lsu_acc, lsu_rd, lsu_wr, if_acc;
    logic [LANES-1:0][DATA_W-1:0] if_word, lsu_word;
    logic lsu_v1, lsu_e1, wr_e1, if_v1, if_e1, lsu_rerr;
    logic [LB-1:0] lsu_bank1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nx;
    end

    always_comb state_nx = (state == CLEAR && cnt == ROW_W'(ROWS-1)) ? RUN : state;

    always_comb begin
        clearing      = state == CLEAR;
        init_done     = state == RUN;
        if_req_ready  = state == RUN;
        lsu_req_ready = state == RUN && !ld_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= '0;
        else if (clearing) cnt <= cnt + 1'b1;
    end

    assign ld_s    = split_addr(32'(ld_addr), LB);
    assign lsu_s   = split_addr(32'(lsu_addr), LB);
    assign if_s    = split_addr(32'(if_pc), LB);
    assign ld_oor  = ld_s.row  >= 32'(ROWS);
    assign lsu_oor = lsu_s.row >= 32'(ROWS);
    assign if_oor  = if_s.row  >= 32'(ROWS);
    assign ld_wr   = ld_valid && init_done && !ld_oor;
    assign lsu_acc = lsu_req_valid && lsu_req_ready;
    assign lsu_rd  = lsu_acc && !lsu_we;
    assign lsu_wr  = lsu_acc && lsu_we;
    assign if_acc  = if_req_valid && if_req_ready;

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic we;
        logic [ROW_W-1:0] wrow;
        logic [DATA_W-1:0] wd;
        logic [DATA_W/8-1:0] be;
        // The clear sweep owns every bank; otherwise the loader wins over the LSU.
        always_comb begin
            we   = clearing || (ld_wr && ld_s.bank == 32'(b)) ||
                   (lsu_wr && !lsu_oor && lsu_s.bank == 32'(b));
            wrow = clearing ? cnt : ld_valid ? ROW_W'(ld_s.row) : ROW_W'(lsu_s.row);
            wd   = clearing ? '0 : ld_valid ? ld_data : lsu_wdata;
            be   = (clearing || ld_valid) ? '1 : lsu_be;
        end
        vliw_mem_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
            .clk(clk), .rst(rst), .we(we), .wrow(wrow), .wdata(wd), .be(be),
            .if_re(if_acc), .if_row(ROW_W'(if_s.row)), .if_zero(if_oor), .if_rdata(if_word[b]),
            .lsu_re(lsu_rd && lsu_s.bank == 32'(b)), .lsu_row(ROW_W'(lsu_s.row)),
            .lsu_zero(lsu_oor), .lsu_rdata(lsu_word[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_v1    <= 1'b0;
            lsu_e1    <= 1'b0;
            wr_e1     <= 1'b0;
            if_v1     <= 1'b0;
            if_e1     <= 1'b0;
            lsu_bank1 <= '0;
        end else begin
            lsu_v1 <= lsu_rd;
            lsu_e1 <= lsu_rd && lsu_oor;
            wr_e1  <= lsu_wr && lsu_oor;
            if_v1  <= if_acc;
            if_e1  <= if_acc && (if_oor || if_s.bank != 32'd0);
            if (lsu_rd) lsu_bank1 <= LB'(lsu_s.bank);
        end
    end

    assign lsu_err = wr_e1 || lsu_rerr;

    if (READ_LAT == 2) begin : g_lat2
        logic lsu_v2, lsu_e2, if_v2, if_e2;
        logic [DATA_W-1:0] lsu_d2;
        logic [LANES*DATA_W-1:0] if_d2;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lsu_v2 <= 1'b0;
                lsu_e2 <= 1'b0;
                if_v2  <= 1'b0;
                if_e2  <= 1'b0;
                lsu_d2 <= '0;
                if_d2  <= '0;
            end else begin
                lsu_v2 <= lsu_v1;
                lsu_e2 <= lsu_e1;
                if_v2  <= if_v1;
                if_e2  <= if_e1;
                if (lsu_v1) lsu_d2 <= lsu_word[lsu_bank1];
                if (if_v1)  if_d2  <= if_word;
            end
        end
        assign lsu_rsp_valid = lsu_v2;
        assign lsu_rdata     = lsu_d2;
        assign lsu_rerr      = lsu_e2;
        assign if_rsp_valid  = if_v2;
        assign if_bundle     = if_d2;
        assign if_err        = if_e2;
    end else begin : g_lat1
        assign lsu_rsp_valid = lsu_v1;
        assign lsu_rdata     = lsu_word[lsu_bank1];
        assign lsu_rerr      = lsu_e1;
        assign if_rsp_valid  = if_v1;
        assign if_bundle     = if_word;
        assign if_err        = if_e1;
    end
endmodule
